// File: rtl/a1339_velocity_estimator.sv
// Per-channel A1339 velocity estimator: windowed velocity, last accepted position, stale flag.
// Define A1339_VEL_GLITCH_REJECT_EN to build MAX_STEP / GLITCH_LIMIT sample rejection.
module a1339_velocity_estimator #(
    parameter int CLOCK_SPEED  = 50_000_000,
    parameter int WINDOW_MS    = 10,
    parameter int TIMEOUT_MS   = 20,
    parameter int MAX_STEP     = 1024,
    parameter int GLITCH_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [31:0] angle_absolute,
    input  logic        resync,
    output logic [31:0] position,
    output logic [31:0] velocity,
    output logic        velocity_valid,
    output logic        stale,
    output logic [15:0] glitch_count
);
    localparam int WINDOW_CYCLES  = CLOCK_SPEED / 1000 * WINDOW_MS;
    localparam int TIMEOUT_CYCLES = CLOCK_SPEED / 1000 * TIMEOUT_MS;
    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALE = 2'd2;

    if (WINDOW_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        MAX_STEP < 0 || GLITCH_LIMIT < 1) begin : g_cfg_check
        $error("a1339_velocity_estimator: invalid parameters");
    end

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [TW-1:0] to_q, to_d;
    logic [39:0]   acc_q, acc_d;
    logic [31:0]   pos_q, pos_d;
    logic [31:0]   vel_q, vel_d;
    logic          vv_q, vv_d;
    logic          stale_q, stale_d;
    logic          full_q, full_d;

    logic        wrap;
    logic        expire;
    logic        in_range;
    logic        take;
    logic [32:0] delta;
    logic [39:0] acc_sum;
    logic [31:0] sat_vel;

    assign wrap   = (win_q == WIN_LAST);
    assign expire = (to_q == TO_MAX);
    assign delta  = {angle_absolute[31], angle_absolute} - {pos_q[31], pos_q};

`ifdef A1339_VEL_GLITCH_REJECT_EN
    localparam int RW = (GLITCH_LIMIT > 1) ? $clog2(GLITCH_LIMIT) : 1;
    localparam logic [RW-1:0] REJ_LAST = RW'(GLITCH_LIMIT - 1);

    logic [15:0]   gc_q, gc_d;
    logic [RW-1:0] rej_q, rej_d;
    logic [32:0]   delta_mag;

    assign delta_mag = delta[32] ? (~delta + 33'd1) : delta;
    assign in_range  = (delta_mag <= 33'(MAX_STEP));
`else
    assign in_range  = 1'b1;
`endif

    assign take = (state_q == S_RUN) && sample_valid && !resync && in_range;
    assign acc_sum = acc_q + (take ? {{7{delta[32]}}, delta} : 40'd0);

    // Clamp the 40-bit window sum into the 32-bit signed output range
    assign sat_vel = (acc_sum[39:31] != {9{acc_sum[39]}})
                   ? (acc_sum[39] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                   : acc_sum[31:0];

    always_comb begin
        state_d = state_q;
        win_d   = wrap ? '0 : win_q + 1'b1;
        to_d    = sample_valid ? '0 : (expire ? to_q : to_q + 1'b1);
        acc_d   = wrap ? '0 : acc_sum;
        pos_d   = pos_q;
        vel_d   = vel_q;
        vv_d    = 1'b0;
        stale_d = stale_q;
        full_d  = full_q;
`ifdef A1339_VEL_GLITCH_REJECT_EN
        gc_d    = gc_q;
        rej_d   = rej_q;
`endif
        if (resync) begin
            state_d = S_INIT;
            win_d   = '0;
            to_d    = '0;
            acc_d   = '0;
            vel_d   = '0;
            stale_d = 1'b0;
            full_d  = 1'b0;
`ifdef A1339_VEL_GLITCH_REJECT_EN
            rej_d   = '0;
`endif
        end else begin
            if (wrap) begin
                vv_d  = 1'b1;
                vel_d = full_q ? sat_vel : '0;
            end
            case (state_q)
                S_RUN: begin
                    if (sample_valid) begin
                        if (take) begin
                            pos_d = angle_absolute;
`ifdef A1339_VEL_GLITCH_REJECT_EN
                            rej_d = '0;
                        end else begin
                            if (gc_q != 16'hFFFF) gc_d = gc_q + 16'd1;
                            if (rej_q == REJ_LAST) begin
                                pos_d = angle_absolute;
                                rej_d = '0;
                            end else begin
                                rej_d = rej_q + 1'b1;
                            end
`endif
                        end
                    end else if (expire) begin
                        state_d = S_STALE;
                        stale_d = 1'b1;
                        acc_d   = '0;
                    end
                end
                default: begin
                    if (sample_valid) begin
                        pos_d   = angle_absolute;
                        stale_d = 1'b0;
                        state_d = S_RUN;
                    end
                end
            endcase
            // A window only reports velocity if it was spent entirely in RUN
            if (wrap) full_d = (state_d == S_RUN);
            else if (state_d != S_RUN) full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            win_q   <= '0;
            to_q    <= '0;
            acc_q   <= '0;
            pos_q   <= '0;
            vel_q   <= '0;
            vv_q    <= 1'b0;
            stale_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            to_q    <= to_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            vv_q    <= vv_d;
            stale_q <= stale_d;
            full_q  <= full_d;
        end
    end

`ifdef A1339_VEL_GLITCH_REJECT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gc_q  <= '0;
            rej_q <= '0;
        end else begin
            gc_q  <= gc_d;
            rej_q <= rej_d;
        end
    end
    assign glitch_count = gc_q;
`else
    assign glitch_count = 16'd0;
`endif

    assign position       = pos_q;
    assign velocity       = vel_q;
    assign velocity_valid = vv_q;
    assign stale          = stale_q;
endmodule

// File: tb/tb_a1339_velocity_estimator.sv
// Scoreboard bench for a1339_velocity_estimator: reference model pushes expected
// window results, a monitor pops and compares on every velocity_valid strobe.
module tb_a1339_velocity_estimator;
    localparam int WC   = 1000;
    localparam int TC   = 5000;
    localparam int MAXS = 1024;
    localparam int GLIM = 4;
`ifdef A1339_VEL_GLITCH_REJECT_EN
    localparam bit GREJ = 1'b1;
`else
    localparam bit GREJ = 1'b0;
`endif
    localparam longint LMAX  = 2147483647;
    localparam longint LMIN  = -LMAX - 1;
    localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [31:0] angle_absolute;
    logic        resync;
    logic [31:0] position;
    logic [31:0] velocity;
    logic        velocity_valid;
    logic        stale;
    logic [15:0] glitch_count;

    always #5 clock = ~clock;

    a1339_velocity_estimator #(
        .CLOCK_SPEED (1_000_000),
        .WINDOW_MS   (1),
        .TIMEOUT_MS  (5),
        .MAX_STEP    (MAXS),
        .GLITCH_LIMIT(GLIM)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sample_valid  (sample_valid),
        .angle_absolute(angle_absolute),
        .resync        (resync),
        .position      (position),
        .velocity      (velocity),
        .velocity_valid(velocity_valid),
        .stale         (stale),
        .glitch_count  (glitch_count)
    );

    typedef struct packed {
        logic [31:0] vel;
        logic [31:0] pos;
        logic        stl;
        logic [15:0] gc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name,
                     $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        longint c;
        c = v;
        if (c > LMAX) c = LMAX;
        if (c < LMIN) c = LMIN;
        return c[31:0];
    endfunction

    // Reference model: absolute cycle index k, window phase, last-sample
    // cycle and the cycle RUN began decide every window result.
    int     m_mode;
    longint k, phase, ls, run_from, acc;
    int     m_pos, m_gc, m_rej;
    bit     m_stl;

    always @(posedge clock) begin : model
        longint d, vexp;
        bit     wrap, full, go_stale;
        exp_t   e;
        if (!reset_n) begin
            m_mode = 0; k = 0; phase = 0; ls = -1; run_from = NEVER;
            acc = 0; m_pos = 0; m_gc = 0; m_rej = 0; m_stl = 0;
        end else begin
            if (resync) begin
                m_mode = 0; acc = 0; m_rej = 0; m_stl = 0;
                phase = k + 1; ls = k; run_from = NEVER;
            end else begin
                wrap = ((k - phase) % WC) == WC - 1;
                full = run_from <= k - (WC - 1);
                go_stale = m_mode == 1 && !sample_valid && (k - ls - 1) >= TC;
                if (sample_valid) ls = k;
                if (sample_valid && m_mode == 1) begin
                    d = longint'($signed(angle_absolute)) - longint'(m_pos);
                    if (!GREJ || (d <= MAXS && d >= -MAXS)) begin
                        acc += d;
                        m_pos = angle_absolute;
                        m_rej = 0;
                    end else begin
                        if (m_gc < 65535) m_gc++;
                        m_rej++;
                        if (m_rej == GLIM) begin
                            m_pos = angle_absolute;
                            m_rej = 0;
                        end
                    end
                end else if (sample_valid) begin
                    m_pos = angle_absolute;
                    m_stl = 0;
                    m_mode = 1;
                    run_from = k + 1;
                end
                vexp = 0;
                if (wrap) begin
                    if (full) vexp = longint'($signed(sat32(acc)));
                    acc = 0;
                end
                if (go_stale) begin
                    m_mode = 2; m_stl = 1; acc = 0; run_from = NEVER;
                end
                if (wrap) begin
                    e.vel = vexp[31:0];
                    e.pos = m_pos;
                    e.stl = m_stl;
                    e.gc  = m_gc[15:0];
                    sbq.push_back(e);
                end
            end
            k++;
        end
    end

    int since_strobe = 0;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (velocity_valid) begin
                since_strobe = 0;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got strobe expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("velocity", velocity, e.vel);
                    chk("position", position, e.pos);
                    chk("stale", {31'd0, stale}, {31'd0, e.stl});
                    chk("glitch_count", {16'd0, glitch_count}, {16'd0, e.gc});
                end
            end else begin
                since_strobe++;
                if (since_strobe > 2 * WC + 20) begin
                    checks++;
                    failures++;
                    $display("FAIL strobe_timeout: got none for %0d cycles",
                             since_strobe);
                    since_strobe = 0;
                end
            end
        end
    end

    task automatic drive(input bit sv, input bit rs, input logic [31:0] a);
        @(negedge clock);
        sample_valid   = sv;
        resync         = rs;
        angle_absolute = a;
        @(negedge clock);
        sample_valid = 1'b0;
        resync       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input int a, input int gap);
        drive(1'b1, 1'b0, a);
        idle(gap);
    endtask

    initial begin : stim
        int cur, r;
        reset_n = 1'b0;
        sample_valid = 1'b0;
        resync = 1'b0;
        angle_absolute = '0;
        idle(3);
        chk("rst_position", position, 32'd0);
        chk("rst_velocity", velocity, 32'd0);
        chk("rst_vvalid", {31'd0, velocity_valid}, 32'd0);
        chk("rst_stale", {31'd0, stale}, 32'd0);
        chk("rst_glitch", {16'd0, glitch_count}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 30; i++) send(100 + 50 * i, 98);
        send(2500, 98);
        send(3400, 98);
        send(4090, 98);
        send(4100, 98);

        drive(1'b0, 1'b1, '0);
        send(1000, 20);
        send(5000, 20);
        send(1010, 20);
        send(1000, 20);
        for (int i = 0; i < 4; i++) send(9000, 20);
        send(9020, 2100);

        idle(5200);
        send(300, 50);
        send(350, 2500);

        send(420, 300);
        drive(1'b1, 1'b1, 32'd777);
        idle(100);
        send(5000, 50);
        send(5010, 2200);

        send(32'h8000_0000, 1050);
        send(32'h7FFF_FFFF, 1050);
        send(32'h8000_0000, 2100);

        cur = 5000;
        drive(1'b0, 1'b1, '0);
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                drive($urandom_range(0, 1) == 1, 1'b1, cur);
            end else if (r < 5) begin
                idle(TC + 100);
            end else if (r < 15) begin
                send($urandom, $urandom_range(1, 40));
            end else begin
                cur = cur + int'($urandom_range(0, 2200)) - 1100;
                send(cur, $urandom_range(1, 150));
            end
        end
        idle(2 * WC + 10);
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
